piso_serial_tx: RTL and testbench

Parallel-in serial-out transmitter: the serializing end of the parallel data path. It accepts a WIDTH-bit parallel word through a valid/ready handshake and shifts it out one bit per clock as a framed serial stream: start bit, data bits, optional parity bit, stop bit. It feeds the serial link whose far end reassembles words into a parallel register.

---
 rtl/piso_serial_tx.sv | 156 +++++++++++++++
 tb/tb_piso_serial_tx.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/piso_serial_tx.sv
// piso_serial_tx
//   Parallel-in serial-out transmitter. Takes a WIDTH-bit word on a
//   valid/ready handshake and sends it as a framed serial stream:
//   start (0), data bits, optional even-parity bit, stop (1).
//
// Parameters
//   WIDTH     : data word width, 1..16
//   MSB_FIRST : 0 = q[0] sent first, 1 = q[WIDTH-1] sent first
//
// Build option
//   PISO_PARITY_EN : when defined, a parity bit (XOR of the data bits)
//                    is sent between the last data bit and the stop bit.
//
// Ports
//   clk     : clock, rising edge
//   rst     : synchronous active-low reset
//   q       : parallel word, sampled on the accept edge only
//   q_valid : word on q is available
//   q_ready : transmitter can take a word (combinational, 0 in reset)
//   sout    : serial line, idles high (registered)
//   sout_en : high while sout carries a frame bit (registered)
//   busy    : high from start bit through stop bit (registered)
//   done    : one-cycle pulse during the stop bit (registered)
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | line idle high, ready for a word
// S_START  | start bit (0) on the line
// S_DATA   | data bits, one per cycle, cnt = bit index
// S_PARITY | even-parity bit (PISO_PARITY_EN only)
// S_STOP   | stop bit (1); a new word may be accepted here

module piso_serial_tx #(
  parameter int WIDTH     = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q,
  input  logic             q_valid,
  output logic             q_ready,
  output logic             sout,
  output logic             sout_en,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef PISO_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_shifted;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  // Gated by rst so a word can never be handshaked during reset.
  assign q_ready = rst && ((state == S_IDLE) || (state == S_STOP));
  assign accept  = q_valid && q_ready;

  // The bit to emit is always at one end of the shift register; the
  // register shifts toward that end each time a data bit goes out.
  assign next_bit      = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign shreg_shifted = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      shreg   <= '0;
      cnt     <= '0;
      sout    <= 1'b1;
      sout_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef PISO_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (accept) begin
      // Accept is only possible in IDLE or STOP; both restart a frame.
      state   <= S_START;
      shreg   <= q;
      cnt     <= '0;
      sout    <= 1'b0;
      sout_en <= 1'b1;
      busy    <= 1'b1;
      done    <= 1'b0;
`ifdef PISO_PARITY_EN
      par     <= ^q;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          sout    <= 1'b1;
          sout_en <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        S_START: begin
          state <= S_DATA;
          sout  <= next_bit;
          shreg <= shreg_shifted;
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
`ifdef PISO_PARITY_EN
            state <= S_PARITY;
            sout  <= par;
`else
            state <= S_STOP;
            sout  <= 1'b1;
            done  <= 1'b1;
`endif
          end else begin
            cnt   <= cnt + CW'(1);
            sout  <= next_bit;
            shreg <= shreg_shifted;
          end
        end
`ifdef PISO_PARITY_EN
        S_PARITY: begin
          state <= S_STOP;
          sout  <= 1'b1;
          done  <= 1'b1;
        end
`endif
        S_STOP: begin
          state   <= S_IDLE;
          sout    <= 1'b1;
          sout_en <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          sout    <= 1'b1;
          sout_en <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serial_tx.sv
module tb_piso_serial_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] q   = 3'b000;
  logic       q_valid = 1'b0;
  logic       q_ready, sout, sout_en, busy, done;

  logic [2:0] qm = 3'b000;
  logic       qm_valid = 1'b0;
  logic       qm_ready, soutm, soutm_en, busym, donem;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  // expected entries: {done, sout} for each frame cycle
  logic [1:0] exp0[$];
  logic [1:0] exp1[$];

  always #5 clk = ~clk;

  piso_serial_tx #(.WIDTH(3), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst), .q(q), .q_valid(q_valid), .q_ready(q_ready),
    .sout(sout), .sout_en(sout_en), .busy(busy), .done(done));

  piso_serial_tx #(.WIDTH(3), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .q(qm), .q_valid(qm_valid), .q_ready(qm_ready),
    .sout(soutm), .sout_en(soutm_en), .busy(busym), .done(donem));

  task automatic check(input string name, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // Hand-built frame: start, data in chosen order, parity, stop.
  // limit truncates the frame (used for the aborted frame).
  task automatic push_frame(input logic [2:0] w, input bit msb, input int limit);
    logic [1:0] f[$];
    f.push_back(2'b00);
    for (int i = 0; i < 3; i++) f.push_back({1'b0, msb ? w[2-i] : w[i]});
`ifdef PISO_PARITY_EN
    f.push_back({1'b0, ^w});
`endif
    f.push_back(2'b11);
    for (int i = 0; i < f.size() && i < limit; i++) begin
      if (msb) exp1.push_back(f[i]);
      else     exp0.push_back(f[i]);
    end
  endtask

  // Present w, wait (bounded) for ready, accept on the next edge.
  // Returns at 1ns into the first frame cycle with q_valid still high.
  task automatic send(input logic [2:0] w, input bit msb, input int limit);
    int n = 0;
    if (msb) begin qm = w; qm_valid = 1'b1; end
    else     begin q  = w; q_valid  = 1'b1; end
    while (!(msb ? qm_ready : q_ready) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("ready_timeout", msb ? qm_ready : q_ready, 1'b1);
    push_frame(w, msb, limit);
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("q_ready", q_ready, rst && (!sout_en || done));
      check("busy_vs_en", busy, sout_en);
      if (sout_en) begin
        if (exp0.size() == 0) check("lsb_unexpected_frame", sout_en, 1'b0);
        else begin
          logic [1:0] e;
          e = exp0.pop_front();
          check("lsb_sout", sout, e[0]);
          check("lsb_done", done, e[1]);
        end
      end else begin
        check("lsb_idle_sout", sout, 1'b1);
        check("lsb_idle_done", done, 1'b0);
      end

      check("m_q_ready", qm_ready, rst && (!soutm_en || donem));
      check("m_busy_vs_en", busym, soutm_en);
      if (soutm_en) begin
        if (exp1.size() == 0) check("msb_unexpected_frame", soutm_en, 1'b0);
        else begin
          logic [1:0] e;
          e = exp1.pop_front();
          check("msb_sout", soutm, e[0]);
          check("msb_done", donem, e[1]);
        end
      end else begin
        check("msb_idle_sout", soutm, 1'b1);
        check("msb_idle_done", donem, 1'b0);
      end
    end
  end

  initial begin
    // reset for 2 cycles, then idle with q_valid low
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    cycles(20);
    check("idle_ready", q_ready, 1'b1);
    check("idle_en", sout_en, 1'b0);

    // basic frame, word changes after accept must not matter
    send(3'b110, 1'b0, 99);
    q_valid = 1'b0; q = 3'b001;
    check("ready_low_in_frame", q_ready, 1'b0);
    cycles(6);

    // back-to-back with q_valid held high
    send(3'b001, 1'b0, 99);
    send(3'b111, 1'b0, 99);
    q_valid = 1'b0; q = 3'b000;
    cycles(8);

    // MSB first instance
    send(3'b100, 1'b1, 99);
    qm_valid = 1'b0; qm = 3'b011;
    cycles(7);

    // reset mid-frame: rst low during frame cycle 3
    send(3'b110, 1'b0, 3);
    q_valid = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(1);
    rst = 1'b1;
    check("abort_sout", sout, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    cycles(2);

    // clean frame after abort
    send(3'b010, 1'b0, 99);
    q_valid = 1'b0;
    cycles(8);

    for (int i = 0; i < 50 && (exp0.size() != 0 || exp1.size() != 0); i++) cycles(1);
    check("lsb_queue_drained", exp0.size() == 0, 1'b1);
    check("msb_queue_drained", exp1.size() == 0, 1'b1);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
